// File: rtl/pa_AsyncCordic.sv
// Shared types and helpers for the asynchronous CORDIC wrapper domain.
// Dual-rail encoding: bit [1] is the true rail, bit [0] the false rail.
//   10 = logic 1, 01 = logic 0, 00 = spacer, 11 = illegal.
package pa_AsyncCordic;

  // Default MSB index of a CORDIC datapath word.
  localparam int unsigned RW = 15;

  typedef logic [1:0] dual_rail_t;

  localparam dual_rail_t DR_SPACER = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_ACKED,
    S_RTZ,
    S_DROP
  } dr_state_e;

  // Only meaningful for a complete codeword.
  function automatic logic dr_to_bin(input dual_rail_t d);
    return d[1];
  endfunction

  function automatic dual_rail_t bin_to_dr(input logic b);
    return b ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dr_completion_detect.sv
// Completion detector for a vector of dual-rail bits.
// Ports:
//   rails        - dual-rail vector under test
//   all_complete - every bit has exactly one rail high
//   all_spacer   - every bit has both rails low
//   any_illegal  - at least one bit has both rails high
module dr_completion_detect
  import pa_AsyncCordic::*;
#(
  parameter int unsigned Width = 1
) (
  input  dual_rail_t [Width-1:0] rails,
  output logic                   all_complete,
  output logic                   all_spacer,
  output logic                   any_illegal
);

  always_comb begin
    all_complete = 1'b1;
    all_spacer   = 1'b1;
    any_illegal  = 1'b0;
    for (int i = 0; i < int'(Width); i++) begin
      all_complete = all_complete & (^rails[i]);
      all_spacer   = all_spacer & (rails[i] == DR_SPACER);
      any_illegal  = any_illegal | (&rails[i]);
    end
  end

endmodule

// File: rtl/sync_dual_rail_demux.sv
// Clocked N-way demultiplexer for dual-rail return-to-zero codewords.
// A complete word plus complete binary select is latched and presented on one
// channel under a four-phase handshake; at most one word is in flight.
// Optional build macro DR_DEMUX_ERR_CHECK_EN enables the sticky err flag
// (illegal rail seen in S_IDLE/S_ACKED, or out-of-range select); otherwise err=0.
// Ports:
//   clk, arst  - clock, synchronous active-high reset
//   data_x     - input codeword (SIZE+1 dual-rail bits)
//   ctrl       - dual-rail binary channel select
//   y_ack      - per-channel consumer acknowledge
//   data_y     - per-channel outputs, spacer when not selected
//   x_ack      - acknowledge to data producer; ctrl_ack mirrors it
//   busy       - FSM not idle
//   chan       - latched channel index (debug)
//   err        - sticky protocol error
module sync_dual_rail_demux
  import pa_AsyncCordic::*;
#(
  parameter int unsigned SIZE  = RW,
  parameter int unsigned NCH   = 4,
  parameter int unsigned SEL_W = $clog2(NCH)
) (
  input  logic                             clk,
  input  logic                             arst,
  input  dual_rail_t [SIZE:0]              data_x,
  input  dual_rail_t [SEL_W-1:0]           ctrl,
  input  logic       [NCH-1:0]             y_ack,
  output dual_rail_t [NCH-1:0][SIZE:0]     data_y,
  output logic                             x_ack,
  output logic                             ctrl_ack,
  output logic                             busy,
  output logic       [SEL_W-1:0]           chan,
  output logic                             err
);

  logic data_complete, data_spacer, data_illegal;
  logic ctrl_complete, ctrl_spacer, ctrl_illegal;

  dr_completion_detect #(
    .Width(SIZE + 1)
  ) u_det_data (
    .rails       (data_x),
    .all_complete(data_complete),
    .all_spacer  (data_spacer),
    .any_illegal (data_illegal)
  );

  dr_completion_detect #(
    .Width(SEL_W)
  ) u_det_ctrl (
    .rails       (ctrl),
    .all_complete(ctrl_complete),
    .all_spacer  (ctrl_spacer),
    .any_illegal (ctrl_illegal)
  );

  logic in_complete, in_spacer, in_illegal;
  assign in_complete = data_complete & ctrl_complete;
  assign in_spacer   = data_spacer & ctrl_spacer;
  assign in_illegal  = data_illegal | ctrl_illegal;

  logic [SEL_W-1:0] sel_in;
  logic             sel_in_range;

  always_comb begin
    sel_in = '0;
    for (int i = 0; i < int'(SEL_W); i++) begin
      sel_in[i] = dr_to_bin(ctrl[i]);
    end
  end

  // NCH need not be a power of two, so some encodable selects are unmapped.
  assign sel_in_range = 32'(sel_in) < NCH;

  dr_state_e               state_q, state_d;
  dual_rail_t [SIZE:0]     word_q, word_d;
  logic       [SEL_W-1:0]  sel_q, sel_d;
  logic                    y_ack_sel;

  // Only the latched channel's acknowledge is ever observed.
  always_comb begin
    y_ack_sel = 1'b0;
    for (int i = 0; i < int'(NCH); i++) begin
      if (sel_q == SEL_W'(i)) y_ack_sel = y_ack[i];
    end
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    sel_d   = sel_q;
    case (state_q)
      S_IDLE: begin
        if (in_complete) begin
          word_d  = data_x;
          sel_d   = sel_in;
          state_d = sel_in_range ? S_SEND : S_DROP;
        end
      end
      S_SEND:  if (y_ack_sel)  state_d = S_ACKED;
      S_ACKED: if (in_spacer)  state_d = S_RTZ;
      S_RTZ:   if (!y_ack_sel) state_d = S_IDLE;
      S_DROP:  if (in_spacer)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    data_y = '0;
    if (state_q == S_SEND || state_q == S_ACKED) begin
      for (int i = 0; i < int'(NCH); i++) begin
        if (sel_q == SEL_W'(i)) data_y[i] = word_q;
      end
    end
  end

  // Decoded straight from the state register, so x_ack is glitch-free.
  assign x_ack    = (state_q == S_ACKED) || (state_q == S_RTZ) || (state_q == S_DROP);
  assign ctrl_ack = x_ack;
  assign busy     = (state_q != S_IDLE);
  assign chan     = sel_q;

`ifdef DR_DEMUX_ERR_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (in_illegal && (state_q == S_IDLE || state_q == S_ACKED)) err_d = 1'b1;
    if (state_q == S_IDLE && in_complete && !sel_in_range)        err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (arst) err_q <= 1'b0;
    else      err_q <= err_d;
  end

  assign err = err_q;
`else
  logic unused_illegal;
  assign unused_illegal = in_illegal;
  assign err = 1'b0;
`endif

endmodule
